// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority-vote sampling and valid/ready output
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   rx          asynchronous serial line, idle high
//   data_out    received payload (DATA_BITS wide, LSB first on the line)
//   valid       data_out and flags valid, held until ready
//   ready       consumer accepts when valid && ready
//   parity_err  parity mismatch for the current data_out
//   frame_err   a stop bit was sampled 0 for the current data_out
//   overrun     1-clk pulse: a frame completed while valid && !ready and was dropped
//   busy        high from start-bit detection until return to idle
//   break_det   1-clk pulse on a line break
//
// Optional feature macro: UART_RX_BREAK_DETECT_EN
//   defined   - an all-zero frame pulses break_det instead of being delivered
//   undefined - break_det is tied 0 and a break is delivered as data 0 with frame_err
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 break_det
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  IDX_A     = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  IDX_B     = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  IDX_C     = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0]  IDX_END   = SC_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       BC_LAST   = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_n;

    logic                 rx_m, rx_s;
    logic [1:0]           settle;
    logic                 armed;
    logic [DIV_W-1:0]     div_cnt;
    logic [SC_W-1:0]      s_cnt;
    logic                 v_a, v_b;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_pend, frm_pend;

    logic tick, mid, bit_end, maj, start_det, frame_done, exp_par, is_break;

    assign tick      = (div_cnt == DIV_LAST);
    assign mid       = tick && (s_cnt == IDX_C);
    assign bit_end   = tick && (s_cnt == IDX_END);
    // Third vote is the live sample, so the decision is made on the third tick.
    assign maj       = (v_a & v_b) | (v_a & rx_s) | (v_b & rx_s);
    assign start_det = (state == S_IDLE) && armed && !rx_s;
    assign exp_par   = (PARITY == 1) ? ~(^shreg) : (^shreg);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_det) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (mid && maj) begin
                    state_n = S_IDLE;
                end else if (bit_end) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_cnt == BC_LAST)) begin
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-bit of the last stop gives half a bit of resync margin.
                if (mid && (stop_cnt == STOP_LAST)) begin
                    frame_done = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic ones_seen;

    assign is_break = frame_done && !(ones_seen || maj);

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_seen <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= is_break;
            if (start_det) begin
                ones_seen <= 1'b0;
            end else if (mid && maj) begin
                ones_seen <= 1'b1;
            end
        end
    end
`else
    assign is_break  = 1'b0;
    assign break_det = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            settle     <= 2'b00;
            armed      <= 1'b0;
            div_cnt    <= '0;
            s_cnt      <= '0;
            v_a        <= 1'b0;
            v_b        <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            par_pend   <= 1'b0;
            frm_pend   <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            // The sync flops reset high; wait until they carry real line samples
            // before arming, so a line held low through reset is not a start.
            settle  <= {settle[0], 1'b1};
            overrun <= 1'b0;

            if (state == S_IDLE) begin
                if (start_det) begin
                    armed    <= 1'b0;
                    div_cnt  <= '0;
                    s_cnt    <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    par_pend <= 1'b0;
                    frm_pend <= 1'b0;
                end else if (settle[1] && rx_s) begin
                    armed <= 1'b1;
                end
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    s_cnt <= (s_cnt == IDX_END) ? '0 : s_cnt + 1'b1;
                    if (s_cnt == IDX_A) begin
                        v_a <= rx_s;
                    end
                    if (s_cnt == IDX_B) begin
                        v_b <= rx_s;
                    end
                end
                if (mid) begin
                    case (state)
                        S_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
                        S_PARITY: if (maj != exp_par) par_pend <= 1'b1;
                        S_STOP:   if (!maj) frm_pend <= 1'b1;
                        default:  ;
                    endcase
                end
                if (bit_end) begin
                    if (state == S_DATA) begin
                        bit_cnt <= (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                    if (state == S_STOP) begin
                        stop_cnt <= 1'b1;
                    end
                end
            end

            // Output register: an accept in the same clk frees it for the new frame.
            if (frame_done && !is_break) begin
                if (!valid || ready) begin
                    data_out   <= shreg;
                    parity_err <= par_pend;
                    frame_err  <= frm_pend | ~maj;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8N1, 8E1 and 8N2 instances)
module tb_uart_rx_cfg;

    localparam int CF = 1600000;
    localparam int BR = 100000;
    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

    logic [7:0] do_a, do_b, do_c;
    logic valid_a, valid_b, valid_c;
    logic pe_a, pe_b, pe_c;
    logic fe_a, fe_b, fe_c;
    logic ov_a, ov_b, ov_c;
    logic busy_a, busy_b, busy_c;
    logic bd_a, bd_b, bd_c;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(do_a), .valid(valid_a),
        .ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a),
        .busy(busy_a), .break_det(bd_a));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data_out(do_b), .valid(valid_b),
        .ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b),
        .busy(busy_b), .break_det(bd_b));

    uart_rx_cfg #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) dut_c (
        .clk(clk), .rst(rst), .rx(rx_c), .data_out(do_c), .valid(valid_c),
        .ready(ready_c), .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c),
        .busy(busy_c), .break_det(bd_c));

    int tests = 0;
    int fails = 0;

    // Expected entries: {data[7:0], parity_err, frame_err}
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] q_c[$];

    int novr_a = 0, novr_bc = 0, nbrk_a = 0, nacc_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] exp,
                           input logic [7:0] d, input logic p, input logic f);
        chk({tag, "_data"}, {24'b0, d}, {24'b0, exp[9:2]});
        chk({tag, "_parity_err"}, {31'b0, p}, {31'b0, exp[1]});
        chk({tag, "_frame_err"}, {31'b0, f}, {31'b0, exp[0]});
    endtask

    always @(negedge clk) begin
        if (ov_a) novr_a++;
        if (ov_b || ov_c) novr_bc++;
        if (bd_a) nbrk_a++;
        if (valid_a && ready_a) begin
            if (q_a.size() == 0) chk("a_spurious_valid", {31'b0, valid_a}, 32'd0);
            else pop_chk("a", q_a.pop_front(), do_a, pe_a, fe_a);
        end
        if (valid_b && ready_b) begin
            if (q_b.size() == 0) chk("b_spurious_valid", {31'b0, valid_b}, 32'd0);
            else pop_chk("b", q_b.pop_front(), do_b, pe_b, fe_b);
        end
        if (valid_c && ready_c) begin
            nacc_c++;
            if (q_c.size() == 0) chk("c_spurious_valid", {31'b0, valid_c}, 32'd0);
            else pop_chk("c", q_c.pop_front(), do_c, pe_c, fe_c);
        end
    end

    // Holds one line at v for one bit time (16 clks), changing it on a falling edge.
    task automatic drive_bit(input int w, input logic v);
        @(negedge clk);
        case (w)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
        repeat (OS - 1) @(negedge clk);
    endtask

    task automatic send_byte(input int w, input logic [7:0] d);
        drive_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
    endtask

    task automatic idle_bits(input int w, input int n);
        for (int i = 0; i < n; i++) drive_bit(w, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs_a", {18'b0, do_a, valid_a, pe_a, fe_a, ov_a, busy_a, bd_a}, 32'd0);
        chk("reset_outs_b", {18'b0, do_b, valid_b, pe_b, fe_b, ov_b, busy_b, bd_b}, 32'd0);
        chk("reset_outs_c", {18'b0, do_c, valid_c, pe_c, fe_c, ov_c, busy_c, bd_c}, 32'd0);
        rst = 1'b0;
        idle_bits(0, 2);

        // 1. 8N1 0xA5
        q_a.push_back({8'hA5, 2'b00});
        send_byte(0, 8'hA5);
        idle_bits(0, 2);
        chk("t1_drained", q_a.size(), 32'd0);

        // 2. even parity: wrong parity bit, then correct ones
        q_b.push_back({8'h07, 2'b10});
        send_byte(1, 8'h07); drive_bit(1, 1'b0); idle_bits(1, 2);
        q_b.push_back({8'h07, 2'b00});
        send_byte(1, 8'h07); drive_bit(1, 1'b1); idle_bits(1, 2);
        q_b.push_back({8'h03, 2'b00});
        send_byte(1, 8'h03); drive_bit(1, 1'b0); idle_bits(1, 2);
        chk("t2_drained", q_b.size(), 32'd0);

        // 3. two stop bits, second one low
        q_c.push_back({8'h3C, 2'b01});
        send_byte(2, 8'h3C);
        drive_bit(2, 1'b1);
        chk("t3_no_valid_before_stop2", nacc_c, 32'd0);
        drive_bit(2, 1'b0);
        idle_bits(2, 1);
        chk("t3_one_valid", nacc_c, 32'd1);
        chk("t3_drained", q_c.size(), 32'd0);

        // 4. overrun with ready low
        @(posedge clk); #1 ready_a = 1'b0;
        q_a.push_back({8'h11, 2'b00});
        send_byte(0, 8'h11); idle_bits(0, 2);
        send_byte(0, 8'h22); idle_bits(0, 2);
        chk("t4_overrun_once", novr_a, 32'd1);
        chk("t4_data_held", {24'b0, do_a}, 32'h11);
        chk("t4_valid_held", {31'b0, valid_a}, 32'd1);
        @(posedge clk); #1 ready_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_valid_dropped", {31'b0, valid_a}, 32'd0);
        chk("t4_drained", q_a.size(), 32'd0);

        // 5a. 5-clk glitch is a false start
        @(negedge clk); rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (9) @(negedge clk);
        chk("t5_glitch_busy_low", {31'b0, busy_a}, 32'd0);
        idle_bits(0, 2);

        // 5b. reset mid-DATA, then a clean frame
        drive_bit(0, 1'b0); drive_bit(0, 1'b1); drive_bit(0, 1'b0);
        chk("t5_busy_mid_frame", {31'b0, busy_a}, 32'd1);
        @(negedge clk); rst = 1'b1; rx_a = 1'b1;
        @(negedge clk);
        chk("t5_reset_outs", {18'b0, do_a, valid_a, pe_a, fe_a, ov_a, busy_a, bd_a}, 32'd0);
        rst = 1'b0;
        idle_bits(0, 2);
        q_a.push_back({8'h5A, 2'b00});
        send_byte(0, 8'h5A); idle_bits(0, 2);
        chk("t5_drained", q_a.size(), 32'd0);

        // 6. line break: 12 bit times low
`ifndef UART_RX_BREAK_DETECT_EN
        q_a.push_back({8'h00, 2'b01});
`endif
        @(negedge clk); rx_a = 1'b0;
        repeat (12 * OS) @(negedge clk);
        rx_a = 1'b1;
        idle_bits(0, 2);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("t6_break_pulses", nbrk_a, 32'd1);
`else
        chk("t6_break_pulses", nbrk_a, 32'd0);
`endif
        chk("t6_drained", q_a.size(), 32'd0);
        chk("t6_overrun_total", novr_a, 32'd1);
        chk("other_overruns", novr_bc, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
